montgomery_const_streamer: RTL and testbench
============================================

# montgomery_const_streamer

Parametrised successor to the Montgomery secondary-input stage of the RSA decryption datapath. Launches the external r/t remainder engine and the n0' engine, waits on both completion pulses with an optional watchdog, latches the DATA_LENGTH-bit constants and streams r and t as DATA_WIDTH-bit word pairs. The output uses a valid/ready handshake, so the modular-multiplier loader can stall it. Word order is selectable: MSW-first or LSW-first.

## Interface
- DATA_LENGTH, 4096: width of r, t, n in bits; integer multiple of DATA_WIDTH.
- DATA_WIDTH, 64: stream word width; NUM_WORDS = DATA_LENGTH/DATA_WIDTH, must be ≥ 2.
- TIMEOUT_CYCLES, 0: watchdog limit in WAIT state; 0 disables the watchdog.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new run; honoured only in IDLE.
- lsw_first  in  1  word order, sampled with start; 1 = least-significant word first.
- compute_start  out  1  one-cycle pulse launching both engines.
- rt_done  in  1  r/t engine completion pulse.
- r_in, t_in  in  DATA_LENGTH  r/t engine results; stable from the rt_done pulse until the next compute_start.
- n0p_done  in  1  n0' engine completion pulse.
- n0p_in  in  DATA_WIDTH  n0' result; valid in the n0p_done cycle.
- n0p  out  DATA_WIDTH  latched n0'; holds its value until the next start.
- out_valid  out  1  a word pair is presented on out_r/out_t.
- out_ready  in  1  consumer accepts the pair.
- out_r, out_t  out  DATA_WIDTH  current words of r and t.
- out_idx  out  clog2(NUM_WORDS)  significance index of the current word; MSW = NUM_WORDS-1.
- out_last  out  1  the current pair is the final one.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the final handshake.
- error  out  1  one-cycle pulse on watchdog expiry.

## Operation
- Reset: state goes to IDLE. Reset values:
  - All outputs 0, including n0p, out_r, out_t, out_idx.
  - Internal flags, counters and shift registers cleared.
  - rst dominates every other input.
- IDLE: on start, latch lsw_first, clear rt_flag, n0p_flag and the watchdog counter, then go to LAUNCH.
- LAUNCH: compute_start = 1 for this cycle only, then go to WAIT.
- WAIT:
  - rt_flag and n0p_flag are sticky. rt_done/n0p_done are also honoured in the LAUNCH cycle, and may be simultaneous.
  - n0p register loads n0p_in on n0p_done.
  - Go to LOAD once both flags are set, including when both set in the same cycle.
  - Watchdog: when TIMEOUT_CYCLES ≠ 0 and the WAIT cycle count reaches TIMEOUT_CYCLES without both flags set, pulse error and go to IDLE. done is not asserted in this case.
- LOAD: copy r_in and t_in into the shift registers, set the word counter to 0, then go to STREAM.
- STREAM:
  - out_valid = 1 throughout.
  - MSW-first: out_r/out_t = top word; each handshake shifts the registers left by DATA_WIDTH.
  - LSW-first: out_r/out_t = bottom word; each handshake shifts right.
  - Handshake = out_valid & out_ready; the counter increments on each one.
  - While out_ready = 0, the outputs hold stable.
  - out_last = 1 when counter = NUM_WORDS-1. The handshake on that word goes to DONE.
  - Exactly NUM_WORDS pairs are emitted per run.
  - out_idx = NUM_WORDS-1-counter when MSW-first, counter when LSW-first.
- DONE: done = 1 for one cycle, out_valid = 0, then go to IDLE.
- In IDLE and DONE, out_r/out_t/out_idx/out_last are 0.
- start outside IDLE is ignored. Done pulses outside LAUNCH/WAIT are ignored.
- rst mid-stream aborts the run: no done, and the counter is not preserved.

## Timing
- start sampled at edge k: compute_start is high in cycle k+1.
- Both flags set by edge m: LOAD in cycle m+1, first out_valid in cycle m+2.
- With out_ready held at 1: words appear in cycles m+2 … m+1+NUM_WORDS, done in cycle m+2+NUM_WORDS, busy low from m+3+NUM_WORDS.
- Minimum run: start to done = NUM_WORDS+4 cycles, when both done pulses arrive in the LAUNCH cycle.
- Outputs are registered. out_ready may be combinationally driven by the consumer; no combinational path exists from out_ready to out_valid.

## Test plan
- DATA_LENGTH=256, DATA_WIDTH=64, MSW-first. r = 0x1111…_2222…_3333…_4444… (64-bit words), t = ~r, rt_done 10 cycles and n0p_done 20 cycles after compute_start, out_ready=1 -> words 0x1111…, 0x2222…, 0x3333…, 0x4444… in consecutive cycles; out_idx 3,2,1,0; out_last on the 4th word; done the following cycle; n0p equals n0p_in.
- Same data, lsw_first=1, out_ready toggling 1,0,1,0 -> order 0x4444…, 0x3333…, 0x2222…, 0x1111…; out_idx 0..3; data stable during stalls; exactly 4 handshakes.
- rt_done and n0p_done in the same cycle as compute_start -> LOAD on the next edge; start-to-done = 8 cycles with out_ready=1.
- TIMEOUT_CYCLES=16 and n0p_done never asserted -> error pulses once after 16 WAIT cycles, state returns to IDLE, done and out_valid stay 0. A new start then completes normally.
- rst asserted during the 2nd word of STREAM -> the next cycle all outputs are 0 and busy=0. A start during busy in another run is ignored: no second compute_start.

Source files
------------

// File: rtl/montgomery_const_streamer_if.sv
// Word-pair stream from the Montgomery constant streamer to the modular-multiplier loader.
interface montgomery_const_streamer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int IDX_W      = 6
);
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_r;
   logic [DATA_WIDTH-1:0] out_t;
   logic [IDX_W-1:0]      out_idx;
   logic                  out_last;

   modport master (
      output out_valid, out_r, out_t, out_idx, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_r, out_t, out_idx, out_last,
      output out_ready
   );
endinterface

// File: rtl/montgomery_const_streamer.sv
// Launches the r/t and n0' engines, waits on both (optional watchdog), then streams
// r and t as DATA_WIDTH-bit word pairs over a valid/ready handshake, MSW- or LSW-first.
module montgomery_const_streamer #(
   parameter int DATA_LENGTH    = 4096,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   lsw_first,
   output logic                   compute_start,
   input  logic                   rt_done,
   input  logic [DATA_LENGTH-1:0] r_in,
   input  logic [DATA_LENGTH-1:0] t_in,
   input  logic                   n0p_done,
   input  logic [DATA_WIDTH-1:0]  n0p_in,
   output logic [DATA_WIDTH-1:0]  n0p,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [2:0]             state_dbg,
   montgomery_const_streamer_if.master stream
);
   // DATA_LENGTH must be a multiple of DATA_WIDTH with at least two words.
   localparam int NUM_WORDS = DATA_LENGTH / DATA_WIDTH;
   localparam int IDX_W     = $clog2(NUM_WORDS);
   localparam int WD_W      = $clog2(TIMEOUT_CYCLES + 2);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_LOAD   = 3'd3,
      ST_STREAM = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t                 state;
   logic                   lsw_q;
   logic                   rt_flag;
   logic                   n0p_flag;
   logic [WD_W-1:0]        wd_cnt;
   logic [IDX_W-1:0]       cnt;
   logic [DATA_LENGTH-1:0] r_sh;
   logic [DATA_LENGTH-1:0] t_sh;

   logic [DATA_LENGTH-1:0] r_nx;
   logic [DATA_LENGTH-1:0] t_nx;
   logic [IDX_W-1:0]       cnt_nx;
   logic                   both_now;
   logic                   wd_expired;

   assign state_dbg  = state;
   assign both_now   = (rt_flag | rt_done) & (n0p_flag | n0p_done);
   assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   function automatic logic [DATA_WIDTH-1:0] pick_word(input logic [DATA_LENGTH-1:0] v,
                                                       input logic lsw);
      return lsw ? v[DATA_WIDTH-1:0] : v[DATA_LENGTH-1 -: DATA_WIDTH];
   endfunction

   always_comb begin
      r_nx   = r_sh;
      t_nx   = t_sh;
      cnt_nx = cnt + 1'b1;
      if (lsw_q) begin
         r_nx = r_sh >> DATA_WIDTH;
         t_nx = t_sh >> DATA_WIDTH;
      end else begin
         r_nx = r_sh << DATA_WIDTH;
         t_nx = t_sh << DATA_WIDTH;
      end
   end

   // Handshake: a pair transfers on any rising edge where out_valid & out_ready.
   // out_valid never depends on out_ready in the same cycle, and once raised the
   // presented pair holds until it transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         lsw_q            <= 1'b0;
         rt_flag          <= 1'b0;
         n0p_flag         <= 1'b0;
         wd_cnt           <= '0;
         cnt              <= '0;
         r_sh             <= '0;
         t_sh             <= '0;
         n0p              <= '0;
         compute_start    <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         stream.out_valid <= 1'b0;
         stream.out_r     <= '0;
         stream.out_t     <= '0;
         stream.out_idx   <= '0;
         stream.out_last  <= 1'b0;
      end else begin
         compute_start <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  lsw_q         <= lsw_first;
                  rt_flag       <= 1'b0;
                  n0p_flag      <= 1'b0;
                  wd_cnt        <= '0;
                  compute_start <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ST_LAUNCH;
               end
            end
            ST_LAUNCH, ST_WAIT: begin
               if (rt_done) rt_flag <= 1'b1;
               if (n0p_done) begin
                  n0p_flag <= 1'b1;
                  n0p      <= n0p_in;
               end
               if (both_now) begin
                  state <= ST_LOAD;
               end else if (state == ST_WAIT && wd_expired) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  if (state == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;
                  state <= ST_WAIT;
               end
            end
            ST_LOAD: begin
               r_sh             <= r_in;
               t_sh             <= t_in;
               cnt              <= '0;
               stream.out_valid <= 1'b1;
               stream.out_r     <= pick_word(r_in, lsw_q);
               stream.out_t     <= pick_word(t_in, lsw_q);
               stream.out_idx   <= lsw_q ? '0 : IDX_W'(NUM_WORDS - 1);
               stream.out_last  <= 1'b0;
               state            <= ST_STREAM;
            end
            ST_STREAM: begin
               if (stream.out_ready) begin
                  if (cnt == IDX_W'(NUM_WORDS - 1)) begin
                     stream.out_valid <= 1'b0;
                     stream.out_r     <= '0;
                     stream.out_t     <= '0;
                     stream.out_idx   <= '0;
                     stream.out_last  <= 1'b0;
                     cnt              <= '0;
                     done             <= 1'b1;
                     state            <= ST_DONE;
                  end else begin
                     r_sh            <= r_nx;
                     t_sh            <= t_nx;
                     cnt             <= cnt_nx;
                     stream.out_r    <= pick_word(r_nx, lsw_q);
                     stream.out_t    <= pick_word(t_nx, lsw_q);
                     stream.out_idx  <= lsw_q ? cnt_nx : IDX_W'(NUM_WORDS - 1) - cnt_nx;
                     stream.out_last <= (cnt_nx == IDX_W'(NUM_WORDS - 1));
                  end
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_montgomery_const_streamer.sv
// Bench for montgomery_const_streamer: table-driven and random runs against a word-list
// model, plus hand-written reset, restart and watchdog sequences.
module tb_montgomery_const_streamer;
   localparam int DL = 256;
   localparam int DW = 64;
   localparam int NW = DL / DW;
   localparam int IW = 2;
   localparam int EW = 2 * DW + IW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_a, start_b;
   logic          lsw_first;
   logic          rt_done, n0p_done;
   logic [DL-1:0] r_in, t_in;
   logic [DW-1:0] n0p_in;

   logic          cs_a, busy_a, done_a, err_a;
   logic [DW-1:0] n0p_a;
   logic [2:0]    st_a;
   logic          cs_b, busy_b, done_b, err_b;
   logic [DW-1:0] n0p_b;
   logic [2:0]    st_b;

   montgomery_const_streamer_if #(.DATA_WIDTH(DW), .IDX_W(IW)) bus_a ();
   montgomery_const_streamer_if #(.DATA_WIDTH(DW), .IDX_W(IW)) bus_b ();

   montgomery_const_streamer #(.DATA_LENGTH(DL), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .lsw_first(lsw_first),
      .compute_start(cs_a), .rt_done(rt_done), .r_in(r_in), .t_in(t_in),
      .n0p_done(n0p_done), .n0p_in(n0p_in), .n0p(n0p_a), .busy(busy_a),
      .done(done_a), .error(err_a), .state_dbg(st_a), .stream(bus_a)
   );

   montgomery_const_streamer #(.DATA_LENGTH(DL), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .lsw_first(lsw_first),
      .compute_start(cs_b), .rt_done(rt_done), .r_in(r_in), .t_in(t_in),
      .n0p_done(n0p_done), .n0p_in(n0p_in), .n0p(n0p_b), .busy(busy_b),
      .done(done_b), .error(err_b), .state_dbg(st_b), .stream(bus_b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic [DL-1:0] r;
      logic [DL-1:0] t;
      logic          lsw;
      int            d_rt;
      int            d_n0p;
      logic [DW-1:0] n0v;
      int            rmode;       // 0 ready=1, 1 toggle 1,0,.., 2 random
      int            restart_s;   // sample index of an extra start while busy, -1 none
      logic [DW-1:0] exp_r0;
      int            exp_done_s;  // expected done sample offset, -1 when stalls make it vary
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [DL-1:0] rand_wide();
      logic [DL-1:0] v = '0;
      for (int j = 0; j < DL / 32; j++) v = {v[DL-33:0], $urandom()};
      return v;
   endfunction

   // Model: word w of a value is (value >> DW*w); order by significance per lsw.
   task automatic load_model(input logic [DL-1:0] r, input logic [DL-1:0] t, input logic lsw);
      exp_q.delete();
      for (int i = 0; i < NW; i++) begin
         int w = lsw ? i : NW - 1 - i;
         logic [DL-1:0] rs = r >> (DW * w);
         logic [DL-1:0] ts = t >> (DW * w);
         exp_q.push_back({rs[DW-1:0], ts[DW-1:0], IW'(w), (i == NW - 1)});
      end
   endtask

   // Sample s is taken 1 time unit after the s-th edge following the start edge.
   task automatic run_case(input vec_t v, input string tag);
      int   hs = 0;
      int   cs_cnt = 0;
      int   done_s = -1;
      logic tog = 1'b1;
      logic rdy;
      logic first_seen = 1'b0;
      load_model(v.r, v.t, v.lsw);
      lsw_first = v.lsw;
      start_a   = 1'b1;
      for (int s = 0; s < 400 && done_s < 0; s++) begin
         @(posedge clk); #1;
         start_a = (s == v.restart_s);
         if (s == 0) check({tag, "_compute_start"}, cs_a, 1'b1);
         if (cs_a) cs_cnt++;
         rdy = 1'(($urandom_range(0, 1)));
         if (bus_a.out_valid) begin
            if (exp_q.size() == 0) begin
               check({tag, "_extra_valid"}, bus_a.out_valid, 1'b0);
            end else begin
               check({tag, "_word"}, {bus_a.out_r, bus_a.out_t, bus_a.out_idx, bus_a.out_last},
                     exp_q[0]);
               if (!first_seen) begin
                  check({tag, "_first_r"}, bus_a.out_r, v.exp_r0);
                  first_seen = 1'b1;
               end
               if (v.rmode == 0) rdy = 1'b1;
               else if (v.rmode == 1) rdy = tog;
               tog = ~tog;
               if (rdy) begin
                  void'(exp_q.pop_front());
                  hs++;
               end
            end
         end
         bus_a.out_ready = rdy;
         if (done_a) begin
            done_s = s;
            check({tag, "_valid_in_done"}, bus_a.out_valid, 1'b0);
         end
         if (s == 0) begin
            r_in = rand_wide();
            t_in = rand_wide();
         end
         rt_done  = (s == v.d_rt);
         n0p_done = (s == v.d_n0p);
         n0p_in   = n0p_done ? v.n0v : {$urandom(), $urandom()};
         if (s == v.d_rt) begin
            r_in = v.r;
            t_in = v.t;
         end
      end
      rt_done  = 1'b0;
      n0p_done = 1'b0;
      check({tag, "_done_seen"}, done_s >= 0, 1'b1);
      if (v.exp_done_s >= 0) check({tag, "_done_latency"}, 256'(done_s), 256'(v.exp_done_s));
      check({tag, "_handshakes"}, 256'(hs), 256'(NW));
      check({tag, "_compute_start_count"}, 256'(cs_cnt), 256'(1));
      check({tag, "_n0p"}, n0p_a, v.n0v);
      @(posedge clk); #1;
      check({tag, "_busy_after"}, busy_a, 1'b0);
      check({tag, "_done_width"}, done_a, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [DL-1:0] r_spec;
      logic [DL-1:0] sh;
      vec_t rv;
      int   err_cnt, err_s, done_cnt, valid_cnt, hs_b, first_idx;
      logic seen_done;

      r_spec = {64'h1111111111111111, 64'h2222222222222222,
                64'h3333333333333333, 64'h4444444444444444};
      vecs[0] = '{r_spec, ~r_spec, 1'b0, 10, 20, 64'h0123456789abcdef, 0, -1,
                  64'h1111111111111111, 26};
      vecs[1] = '{r_spec, ~r_spec, 1'b1, 10, 20, 64'hfeedfacecafebeef, 1, 5,
                  64'h4444444444444444, -1};
      vecs[2] = '{r_spec, ~r_spec, 1'b0, 0, 0, 64'h00000000deadbeef, 0, 3,
                  64'h1111111111111111, 6};
      vecs[3] = '{r_spec, ~r_spec, 1'b1, 7, 3, 64'h8000000000000001, 0, -1,
                  64'h4444444444444444, 13};

      // Clock/reset
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; lsw_first = 1'b0;
      rt_done = 1'b0; n0p_done = 1'b0; r_in = '0; t_in = '0; n0p_in = '0;
      bus_a.out_ready = 1'b0; bus_b.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_a", {cs_a, busy_a, done_a, err_a, n0p_a, st_a, bus_a.out_valid,
            bus_a.out_r, bus_a.out_t, bus_a.out_idx, bus_a.out_last}, 256'(0));
      check("reset_outputs_b", {cs_b, busy_b, done_b, err_b, n0p_b, st_b, bus_b.out_valid,
            bus_b.out_r, bus_b.out_t, bus_b.out_idx, bus_b.out_last}, 256'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) run_case(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         rv.r = rand_wide();
         rv.t = rand_wide();
         rv.lsw = 1'($urandom_range(0, 1));
         rv.d_rt = $urandom_range(0, 12);
         rv.d_n0p = $urandom_range(0, 12);
         rv.n0v = {$urandom(), $urandom()};
         rv.rmode = $urandom_range(0, 2);
         rv.restart_s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : -1;
         sh = rv.r >> (rv.lsw ? 0 : DW * (NW - 1));
         rv.exp_r0 = sh[DW-1:0];
         rv.exp_done_s = (rv.rmode == 0) ?
                         2 + NW + ((rv.d_rt > rv.d_n0p) ? rv.d_rt : rv.d_n0p) : -1;
         run_case(rv, $sformatf("rand%0d", i));
      end

      // Reset during the second word of an MSW-first run
      r_in = r_spec; t_in = ~r_spec; lsw_first = 1'b0; bus_a.out_ready = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; rt_done = 1'b1; n0p_done = 1'b1; n0p_in = 64'h55;
      first_idx = -1;
      for (int s = 0; s < 20 && first_idx < 0; s++) begin
         @(posedge clk); #1;
         rt_done = 1'b0; n0p_done = 1'b0;
         if (bus_a.out_valid && bus_a.out_idx == 2'd2) first_idx = s;
      end
      check("midrst_second_word_seen", first_idx >= 0, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_outputs_zero", {cs_a, done_a, err_a, n0p_a, bus_a.out_valid, bus_a.out_r,
            bus_a.out_t, bus_a.out_idx, bus_a.out_last}, 256'(0));
      check("midrst_busy", busy_a, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      run_case(vecs[0], "post_rst");

      // Watchdog: n0p_done never arrives on the 16-cycle instance
      err_cnt = 0; err_s = -1; done_cnt = 0; valid_cnt = 0;
      start_b = 1'b1;
      for (int s = 0; s < 40; s++) begin
         @(posedge clk); #1;
         start_b = 1'b0;
         if (err_b) begin
            err_cnt++;
            err_s = s;
            check("wd_idle_on_error", busy_b, 1'b0);
         end
         if (done_b) done_cnt++;
         if (bus_b.out_valid) valid_cnt++;
         rt_done = (s == 2);
      end
      rt_done = 1'b0;
      check("wd_error_time", 256'(err_s), 256'(17));
      check("wd_error_count", 256'(err_cnt), 256'(1));
      check("wd_no_done", 256'(done_cnt), 256'(0));
      check("wd_no_valid", 256'(valid_cnt), 256'(0));

      // Fresh run on the watchdog instance after expiry
      hs_b = 0; seen_done = 1'b0; err_cnt = 0; first_idx = -1;
      lsw_first = 1'b0; r_in = r_spec; t_in = ~r_spec;
      start_b = 1'b1;
      for (int s = 0; s < 40 && !seen_done; s++) begin
         @(posedge clk); #1;
         start_b = 1'b0;
         if (err_b) err_cnt++;
         if (bus_b.out_valid) begin
            if (first_idx < 0) first_idx = int'(bus_b.out_idx);
            hs_b++;
         end
         if (done_b) seen_done = 1'b1;
         rt_done  = (s == 3);
         n0p_done = (s == 3);
         n0p_in   = 64'h77;
      end
      rt_done = 1'b0; n0p_done = 1'b0;
      check("wd_rerun_done", seen_done, 1'b1);
      check("wd_rerun_handshakes", 256'(hs_b), 256'(NW));
      check("wd_rerun_first_idx", 256'(first_idx), 256'(NW - 1));
      check("wd_rerun_no_error", 256'(err_cnt), 256'(0));
      check("wd_rerun_n0p", n0p_b, 64'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
